// File: rtl/pipelined_addsub.sv
// Pipelined two's-complement adder/subtractor. Each stage resolves CHUNK bits of the carry chain.
// The pipeline has a valid/ready handshake, optional signed saturation, and C/V/Z/N flags.
module pipelined_addsub #(
  parameter int WIDTH = 16,
  parameter int CHUNK = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             m,
  input  logic             sat,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] s,
  output logic             carry,
  output logic             v,
  output logic             z,
  output logic             n
);

  localparam int STAGES = WIDTH / CHUNK;
  localparam int LAST   = STAGES - 1;

  // Stage k registers hold the operands for slice k, shifted so that the slice sits in
  // the low CHUNK bits. They also hold the slices resolved so far, packed from the top.
  logic [WIDTH-1:0] a_reg   [STAGES];
  logic [WIDTH-1:0] b_reg   [STAGES];
  logic [WIDTH-1:0] sum_reg [STAGES];
  logic             cy_reg  [STAGES];
  logic             sat_reg [STAGES];
  logic             vld_reg [STAGES];

  logic [WIDTH-1:0] a_next   [STAGES];
  logic [WIDTH-1:0] b_next   [STAGES];
  logic [WIDTH-1:0] sum_next [STAGES];
  logic             cy_next  [STAGES];
  logic             sat_next [STAGES];
  logic             vld_next [STAGES];

  logic [CHUNK-1:0] slice_sum [STAGES];
  logic             slice_cy  [STAGES];

  logic stall;

  assign out_valid = vld_reg[LAST];
  assign stall     = out_valid && !out_ready;
  assign in_ready  = !stall;

  for (genvar gi = 0; gi < STAGES; gi++) begin : g_stage
    assign {slice_cy[gi], slice_sum[gi]} = {1'b0, a_reg[gi][CHUNK-1:0]}
                                         + {1'b0, b_reg[gi][CHUNK-1:0]}
                                         + (CHUNK+1)'(cy_reg[gi]);

    if (gi == 0) begin : g_capture
      // Mode is folded in here as inverted B plus carry-in, so m itself need not travel.
      assign a_next[gi]   = a;
      assign b_next[gi]   = b ^ {WIDTH{m}};
      assign sum_next[gi] = '0;
      assign cy_next[gi]  = m;
      assign sat_next[gi] = sat;
      assign vld_next[gi] = in_valid;
    end else begin : g_advance
      assign a_next[gi]   = a_reg[gi-1] >> CHUNK;
      assign b_next[gi]   = b_reg[gi-1] >> CHUNK;
      assign sum_next[gi] = (sum_reg[gi-1] >> CHUNK) | (WIDTH'(slice_sum[gi-1]) << (WIDTH - CHUNK));
      assign cy_next[gi]  = slice_cy[gi-1];
      assign sat_next[gi] = sat_reg[gi-1];
      assign vld_next[gi] = vld_reg[gi-1];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int k = 0; k < STAGES; k++) begin
        a_reg[k]   <= '0;
        b_reg[k]   <= '0;
        sum_reg[k] <= '0;
        cy_reg[k]  <= 1'b0;
        sat_reg[k] <= 1'b0;
        vld_reg[k] <= 1'b0;
      end
    end else if (!stall) begin
      for (int k = 0; k < STAGES; k++) begin
        a_reg[k]   <= a_next[k];
        b_reg[k]   <= b_next[k];
        sum_reg[k] <= sum_next[k];
        cy_reg[k]  <= cy_next[k];
        sat_reg[k] <= sat_next[k];
        vld_reg[k] <= vld_next[k];
      end
    end
  end

  logic [WIDTH-1:0] raw_sum;
  logic [WIDTH-1:0] s_fin;
  logic             msb_cin;
  logic             v_raw;

  // The carry into the MSB is recovered from the MSB sum bit and its two operand bits.
  always_comb begin
    raw_sum = (sum_reg[LAST] >> CHUNK) | (WIDTH'(slice_sum[LAST]) << (WIDTH - CHUNK));
    msb_cin = a_reg[LAST][CHUNK-1] ^ b_reg[LAST][CHUNK-1] ^ raw_sum[WIDTH-1];
    v_raw   = msb_cin ^ slice_cy[LAST];
    s_fin   = raw_sum;
    if (sat_reg[LAST] && v_raw) begin
      s_fin = raw_sum[WIDTH-1] ? {1'b0, {(WIDTH-1){1'b1}}} : {1'b1, {(WIDTH-1){1'b0}}};
    end
  end

  assign s     = out_valid ? s_fin : '0;
  assign carry = out_valid && slice_cy[LAST];
  assign v     = out_valid && v_raw;
  assign z     = out_valid && (s_fin == '0);
  assign n     = out_valid && s_fin[WIDTH-1];

endmodule

// File: tb/tb_pipelined_addsub.sv
// Directed self-checking bench for pipelined_addsub (WIDTH=16, CHUNK=4, latency 4).
module tb_pipelined_addsub;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] a;
  logic [15:0] b;
  logic        m;
  logic        sat;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] s;
  logic        carry;
  logic        v;
  logic        z;
  logic        n;

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct {
    logic [15:0] ta;
    logic [15:0] tb;
    logic        tm;
    logic        tsat;
    logic [15:0] es;
    logic [3:0]  ef;  // {carry, v, z, n}
  } vec_t;

  pipelined_addsub #(.WIDTH(16), .CHUNK(4)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .m(m), .sat(sat),
    .out_valid(out_valid), .out_ready(out_ready),
    .s(s), .carry(carry), .v(v), .z(z), .n(n)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got timeout want completion");
    $fatal(1);
  end

  // Drives one op at a negedge and returns the number of cycles until out_valid (-1 on timeout).
  task automatic issue_and_wait(input logic [15:0] ta, input logic [15:0] tb_, input logic tm,
                                input logic tsat, output int lat);
    @(negedge clk);
    a = ta; b = tb_; m = tm; sat = tsat; in_valid = 1'b1;
    lat = -1;
    for (int k = 1; k <= 20; k++) begin
      @(negedge clk);
      in_valid = 1'b0;
      if (out_valid) begin
        lat = k;
        break;
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; in_valid = 1'b1; a = 16'h0005; b = 16'h0005; m = 1'b0; sat = 1'b0; out_ready = 1'b1;
    repeat (3) @(negedge clk);
    in_valid = 1'b0; rst = 1'b0;
    $display("reset released: out_valid=%b in_ready=%b s=%h flags=%b%b%b%b", out_valid, in_ready, s, carry, v, z, n);
    n_checks++;
    if ({out_valid, s, carry, v, z, n} !== 21'd0) begin
      n_fail++; $display("FAIL reset_outputs: got %b_%h_%b%b%b%b want 0_0000_0000", out_valid, s, carry, v, z, n);
    end
    n_checks++;
    if (in_ready !== 1'b1) begin
      n_fail++; $display("FAIL reset_in_ready: got %b want 1", in_ready);
    end
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      n_checks++;
      if (out_valid !== 1'b0) begin
        n_fail++; $display("FAIL reset_dropped_op cycle %0d: got out_valid=%b want 0", k, out_valid);
      end
    end
  endtask

  task automatic test_add_sat();
    vec_t tv [2];
    int lat;
    tv[0] = '{16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h8000, 4'b0101};
    tv[1] = '{16'h7FFF, 16'h0001, 1'b0, 1'b1, 16'h7FFF, 4'b0100};
    for (int i = 0; i < 2; i++) begin
      issue_and_wait(tv[i].ta, tv[i].tb, tv[i].tm, tv[i].tsat, lat);
      $display("add %h+%h sat=%b -> s=%h cvzn=%b%b%b%b lat=%0d", tv[i].ta, tv[i].tb, tv[i].tsat, s, carry, v, z, n, lat);
      n_checks++;
      if (lat !== 4) begin n_fail++; $display("FAIL add_latency[%0d]: got %0d want 4", i, lat); end
      n_checks++;
      if ({s, carry, v, z, n} !== {tv[i].es, tv[i].ef}) begin
        n_fail++; $display("FAIL add_result[%0d]: got %h/%b%b%b%b want %h/%b", i, s, carry, v, z, n, tv[i].es, tv[i].ef);
      end
    end
  endtask

  task automatic test_sub();
    vec_t tv [2];
    int lat;
    tv[0] = '{16'h0005, 16'h0005, 1'b1, 1'b0, 16'h0000, 4'b1010};
    tv[1] = '{16'h0003, 16'h0005, 1'b1, 1'b0, 16'hFFFE, 4'b0001};
    for (int i = 0; i < 2; i++) begin
      issue_and_wait(tv[i].ta, tv[i].tb, tv[i].tm, tv[i].tsat, lat);
      $display("sub %h-%h -> s=%h cvzn=%b%b%b%b lat=%0d", tv[i].ta, tv[i].tb, s, carry, v, z, n, lat);
      n_checks++;
      if (lat !== 4) begin n_fail++; $display("FAIL sub_latency[%0d]: got %0d want 4", i, lat); end
      n_checks++;
      if ({s, carry, v, z, n} !== {tv[i].es, tv[i].ef}) begin
        n_fail++; $display("FAIL sub_result[%0d]: got %h/%b%b%b%b want %h/%b", i, s, carry, v, z, n, tv[i].es, tv[i].ef);
      end
    end
  endtask

  task automatic test_carry_chain();
    vec_t tv [2];
    int lat;
    tv[0] = '{16'h0FFF, 16'h0001, 1'b0, 1'b0, 16'h1000, 4'b0000};
    tv[1] = '{16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 4'b1010};
    for (int i = 0; i < 2; i++) begin
      issue_and_wait(tv[i].ta, tv[i].tb, tv[i].tm, tv[i].tsat, lat);
      $display("carry %h+%h -> s=%h cvzn=%b%b%b%b lat=%0d", tv[i].ta, tv[i].tb, s, carry, v, z, n, lat);
      n_checks++;
      if (lat !== 4) begin n_fail++; $display("FAIL carry_latency[%0d]: got %0d want 4", i, lat); end
      n_checks++;
      if ({s, carry, v, z, n} !== {tv[i].es, tv[i].ef}) begin
        n_fail++; $display("FAIL carry_result[%0d]: got %h/%b%b%b%b want %h/%b", i, s, carry, v, z, n, tv[i].es, tv[i].ef);
      end
    end
  endtask

  task automatic test_neg_sat();
    vec_t tv [2];
    int lat;
    tv[0] = '{16'h8000, 16'h0001, 1'b1, 1'b1, 16'h8000, 4'b1101};
    tv[1] = '{16'h8000, 16'h0001, 1'b1, 1'b0, 16'h7FFF, 4'b1100};
    for (int i = 0; i < 2; i++) begin
      issue_and_wait(tv[i].ta, tv[i].tb, tv[i].tm, tv[i].tsat, lat);
      $display("negsat %h-%h sat=%b -> s=%h cvzn=%b%b%b%b lat=%0d", tv[i].ta, tv[i].tb, tv[i].tsat, s, carry, v, z, n, lat);
      n_checks++;
      if (lat !== 4) begin n_fail++; $display("FAIL negsat_latency[%0d]: got %0d want 4", i, lat); end
      n_checks++;
      if ({s, carry, v, z, n} !== {tv[i].es, tv[i].ef}) begin
        n_fail++; $display("FAIL negsat_result[%0d]: got %h/%b%b%b%b want %h/%b", i, s, carry, v, z, n, tv[i].es, tv[i].ef);
      end
    end
  endtask

  // Four ops on consecutive cycles with mixed modes; results must come out on consecutive cycles.
  task automatic test_back_to_back();
    logic [15:0] ta [4] = '{16'h1234, 16'h1234, 16'h00FF, 16'h0000};
    logic [15:0] tb_ [4] = '{16'h1111, 16'h1111, 16'h0001, 16'h0001};
    logic        tm [4] = '{1'b0, 1'b1, 1'b0, 1'b1};
    logic [15:0] es [4] = '{16'h2345, 16'h0123, 16'h0100, 16'hFFFF};
    logic [3:0]  ec = 4'b0100;  // carry per op
    for (int t = 0; t < 9; t++) begin
      @(negedge clk);
      n_checks++;
      if (out_valid !== (t >= 4 && t < 8)) begin
        n_fail++; $display("FAIL b2b_valid t=%0d: got %b want %b", t, out_valid, (t >= 4 && t < 8));
      end
      if (t >= 4 && t < 8) begin
        $display("b2b result %0d: s=%h carry=%b", t - 4, s, carry);
        n_checks++;
        if ({s, carry} !== {es[t-4], ec[3-(t-4)]}) begin
          n_fail++; $display("FAIL b2b_result[%0d]: got %h/%b want %h/%b", t - 4, s, carry, es[t-4], ec[3-(t-4)]);
        end
      end
      if (t < 4) begin
        a = ta[t]; b = tb_[t]; m = tm[t]; sat = 1'b0; in_valid = 1'b1;
      end else begin
        in_valid = 1'b0;
      end
    end
  endtask

  task automatic test_backpressure();
    int sent = 0;
    int recv = 0;
    int cyc = 0;
    int stalls = 0;
    logic stalled_prev = 1'b0;
    logic exp_stall;
    logic [15:0] s_prev = '0;
    logic extra = 1'b0;
    while (recv < 8 && cyc < 80) begin
      @(negedge clk);
      out_ready = (cyc % 3 == 0);
      in_valid = (sent < 8);
      a = 16'(sent); b = 16'(sent); m = 1'b0; sat = 1'b0;
      #1;
      exp_stall = out_valid && !out_ready;
      if (exp_stall) stalls++;
      n_checks++;
      if (in_ready !== !exp_stall) begin
        n_fail++; $display("FAIL bp_in_ready cyc=%0d: got %b want %b", cyc, in_ready, !exp_stall);
      end
      if (stalled_prev) begin
        n_checks++;
        if ({out_valid, s} !== {1'b1, s_prev}) begin
          n_fail++; $display("FAIL bp_stable cyc=%0d: got %b/%h want 1/%h", cyc, out_valid, s, s_prev);
        end
      end
      if (out_valid && out_ready) begin
        $display("bp result %0d: s=%h cyc=%0d", recv, s, cyc);
        n_checks++;
        if (s !== 16'(2 * recv)) begin
          n_fail++; $display("FAIL bp_result[%0d]: got %h want %h", recv, s, 16'(2 * recv));
        end
        recv++;
      end
      if (in_valid && in_ready) sent++;
      stalled_prev = exp_stall;
      s_prev = s;
      cyc++;
    end
    n_checks++;
    if (recv != 8 || sent != 8 || stalls == 0) begin
      n_fail++; $display("FAIL bp_counts: got recv=%0d sent=%0d stalls=%0d want 8/8/>0", recv, sent, stalls);
    end
    @(negedge clk);
    in_valid = 1'b0; out_ready = 1'b1;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      if (out_valid) extra = 1'b1;
    end
    n_checks++;
    if (extra !== 1'b0) begin
      n_fail++; $display("FAIL bp_duplicate: got extra out_valid=%b want 0", extra);
    end
  endtask

  task automatic test_reset_midflight();
    int lat;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      a = 16'(i + 1); b = 16'h0001; m = 1'b0; sat = 1'b0; in_valid = 1'b1;
    end
    @(negedge clk);
    in_valid = 1'b0; rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    for (int k = 0; k < 4; k++) begin
      n_checks++;
      if (out_valid !== 1'b0) begin
        n_fail++; $display("FAIL midrst_flushed k=%0d: got out_valid=%b want 0", k, out_valid);
      end
      @(negedge clk);
    end
    issue_and_wait(16'h0042, 16'h0001, 1'b0, 1'b0, lat);
    $display("post-reset op 0042+0001 -> s=%h lat=%0d", s, lat);
    n_checks++;
    if (lat !== 4) begin n_fail++; $display("FAIL midrst_latency: got %0d want 4", lat); end
    n_checks++;
    if (s !== 16'h0043) begin n_fail++; $display("FAIL midrst_result: got %h want 0043", s); end
    @(negedge clk);
    n_checks++;
    if (out_valid !== 1'b0) begin
      n_fail++; $display("FAIL midrst_alone: got out_valid=%b want 0", out_valid);
    end
  endtask

  initial begin
    test_reset();
    test_add_sat();
    test_sub();
    test_carry_chain();
    test_neg_sat();
    test_back_to_back();
    test_backpressure();
    test_reset_midflight();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
